// File: rtl/alu_op_decoder_if.sv
// ALU operation bus: instruction beats in, decoded ALU control beats out.
// The master modport is the decoder side; the slave modport is the fetch/ALU environment.
interface alu_op_decoder_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_alu_op;
    logic [1:0]      out_a_sel;
    logic            out_b_sel;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic            out_rd_we;
    logic            out_illegal;
    logic [XLEN-1:0] out_pc;

    modport master (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_alu_op, out_a_sel, out_b_sel, out_imm,
               out_rs1, out_rs2, out_rd, out_rd_we, out_illegal, out_pc
    );

    modport slave (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_alu_op, out_a_sel, out_b_sel, out_imm,
               out_rs1, out_rs2, out_rd, out_rd_we, out_illegal, out_pc
    );
endinterface

// File: rtl/alu_op_decoder.sv
// RV32I instruction decoder feeding the ALU stage: combinational decode, one output
// register and one skid entry so in_ready comes straight from a flop.
module alu_op_decoder #(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    alu_op_decoder_if.master   bus
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] A_RS1  = 2'b00;
    localparam logic [1:0] A_PC   = 2'b01;
    localparam logic [1:0] A_ZERO = 2'b10;

    typedef struct packed {
        logic [3:0]      alu_op;
        logic [1:0]      a_sel;
        logic            b_sel;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rd_we;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } dec_t;

    function automatic logic [XLEN-1:0] imm_i(input logic [31:0] i);
        return {{(XLEN-12){i[31]}}, i[31:20]};
    endfunction

    function automatic logic [XLEN-1:0] imm_s(input logic [31:0] i);
        return {{(XLEN-12){i[31]}}, i[31:25], i[11:7]};
    endfunction

    function automatic logic [XLEN-1:0] imm_b(input logic [31:0] i);
        return {{(XLEN-13){i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [XLEN-1:0] imm_u(input logic [31:0] i);
        return {i[31:12], 12'b0};
    endfunction

    function automatic logic [XLEN-1:0] imm_j(input logic [31:0] i);
        return {{(XLEN-21){i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic logic [XLEN-1:0] imm_shamt(input logic [31:0] i);
        return {{(XLEN-5){1'b0}}, i[24:20]};
    endfunction

    // alt selects SUB on funct3=000 and SRA on funct3=101
    function automatic logic [3:0] op_from_f3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? OP_SUB : OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = alt ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

    // ---- p0: combinational decode of the offered instruction
    dec_t       dec_p0;
    logic [3:0] op_p0;
    logic       wr_p0;
    logic       ill_p0;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = bus.in_instr[6:0];
    assign f3     = bus.in_instr[14:12];
    assign f7     = bus.in_instr[31:25];

    always_comb begin
        dec_p0       = '0;
        op_p0        = OP_ADD;
        wr_p0        = 1'b0;
        ill_p0       = 1'b0;
        dec_p0.rs1   = bus.in_instr[19:15];
        dec_p0.rs2   = bus.in_instr[24:20];
        dec_p0.rd    = bus.in_instr[11:7];
        dec_p0.pc    = bus.in_pc;
        dec_p0.a_sel = A_RS1;
        case (opcode)
            OPC_OP: begin
                wr_p0 = 1'b1;
                op_p0 = op_from_f3(f3, f7 == 7'h20);
                if (f7 != 7'h00 && f7 != 7'h20)
                    ill_p0 = 1'b1;
                else if (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101)
                    ill_p0 = 1'b1;
            end
            OPC_OPIMM: begin
                wr_p0        = 1'b1;
                dec_p0.b_sel = 1'b1;
                dec_p0.imm   = imm_i(bus.in_instr);
                op_p0        = op_from_f3(f3, 1'b0);
                if (f3 == 3'b001) begin
                    dec_p0.imm = imm_shamt(bus.in_instr);
                    ill_p0     = (f7 != 7'h00);
                end else if (f3 == 3'b101) begin
                    dec_p0.imm = imm_shamt(bus.in_instr);
                    op_p0      = op_from_f3(f3, f7 == 7'h20);
                    ill_p0     = (f7 != 7'h00 && f7 != 7'h20);
                end
            end
            OPC_LOAD: begin
                wr_p0        = 1'b1;
                dec_p0.b_sel = 1'b1;
                dec_p0.imm   = imm_i(bus.in_instr);
                ill_p0       = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
            end
            OPC_STORE: begin
                dec_p0.b_sel = 1'b1;
                dec_p0.imm   = imm_s(bus.in_instr);
                ill_p0       = (f3 >= 3'b011);
            end
            OPC_JALR: begin
                wr_p0        = 1'b1;
                dec_p0.b_sel = 1'b1;
                dec_p0.imm   = imm_i(bus.in_instr);
            end
            OPC_LUI: begin
                wr_p0        = 1'b1;
                dec_p0.a_sel = A_ZERO;
                dec_p0.b_sel = 1'b1;
                dec_p0.imm   = imm_u(bus.in_instr);
            end
            OPC_AUIPC: begin
                wr_p0        = 1'b1;
                dec_p0.a_sel = A_PC;
                dec_p0.b_sel = 1'b1;
                dec_p0.imm   = imm_u(bus.in_instr);
            end
            OPC_JAL: begin
                wr_p0        = 1'b1;
                dec_p0.a_sel = A_PC;
                dec_p0.b_sel = 1'b1;
                dec_p0.imm   = imm_j(bus.in_instr);
            end
            OPC_BRANCH: begin
                dec_p0.imm = imm_b(bus.in_instr);
                case (f3)
                    3'b000, 3'b001: op_p0 = OP_SUB;
                    3'b100, 3'b101: op_p0 = OP_SLT;
                    3'b110, 3'b111: op_p0 = OP_SLTU;
                    default:        ill_p0 = 1'b1;
                endcase
            end
            OPC_FENCE, OPC_SYSTEM: begin
                op_p0 = OP_ADD;
            end
            default: ill_p0 = 1'b1;
        endcase
        dec_p0.illegal = ill_p0;
        dec_p0.alu_op  = ill_p0 ? OP_ADD : op_p0;
        dec_p0.rd_we   = wr_p0 && !ill_p0 && (dec_p0.rd != 5'd0);
    end

    // ---- p1: output register plus skid entry
    dec_t out_p1;
    dec_t skid_p1;
    logic vld_p1;
    logic vld_skid_p1;
    logic accept;
    logic slot_free;

    assign bus.in_ready = !vld_skid_p1;
    assign accept       = bus.in_valid && !vld_skid_p1 && !flush;
    assign slot_free    = !vld_p1 || bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_p1      <= 1'b0;
            vld_skid_p1 <= 1'b0;
            out_p1      <= '0;
            skid_p1     <= '0;
        end else if (slot_free) begin
            // skid is always older than anything offered now, and in_ready was low
            if (vld_skid_p1) begin
                out_p1      <= skid_p1;
                vld_p1      <= 1'b1;
                vld_skid_p1 <= 1'b0;
            end else if (accept) begin
                out_p1 <= dec_p0;
                vld_p1 <= 1'b1;
            end else begin
                vld_p1 <= 1'b0;
            end
        end else if (accept) begin
            skid_p1     <= dec_p0;
            vld_skid_p1 <= 1'b1;
        end
    end

    assign bus.out_valid   = vld_p1;
    assign bus.out_alu_op  = out_p1.alu_op;
    assign bus.out_a_sel   = out_p1.a_sel;
    assign bus.out_b_sel   = out_p1.b_sel;
    assign bus.out_imm     = out_p1.imm;
    assign bus.out_rs1     = out_p1.rs1;
    assign bus.out_rs2     = out_p1.rs2;
    assign bus.out_rd      = out_p1.rd;
    assign bus.out_rd_we   = out_p1.rd_we;
    assign bus.out_illegal = out_p1.illegal;
    assign bus.out_pc      = out_p1.pc;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed bench for alu_op_decoder: decode vectors, backpressure/skid ordering,
// flush and mid-stream reset.
module tb_alu_op_decoder;
    logic clk;
    logic rst;
    logic flush;
    int   checks;
    int   failures;

    alu_op_decoder_if #(.XLEN(32)) bus ();

    alu_op_decoder #(.XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_alu_op", bus.out_alu_op, 0);
        chk("rst_imm", bus.out_imm, 0);
        chk("rst_pc", bus.out_pc, 0);

        // decode vectors, one per cycle
        offer(32'h002081B3, 32'h100);
        step();
        chk("add_valid", bus.out_valid, 1);
        chk("add_op", bus.out_alu_op, 0);
        chk("add_a_sel", bus.out_a_sel, 0);
        chk("add_b_sel", bus.out_b_sel, 0);
        chk("add_rs1", bus.out_rs1, 1);
        chk("add_rs2", bus.out_rs2, 2);
        chk("add_rd", bus.out_rd, 3);
        chk("add_rd_we", bus.out_rd_we, 1);
        chk("add_illegal", bus.out_illegal, 0);
        chk("add_pc", bus.out_pc, 32'h100);

        offer(32'h402081B3, 32'h104);
        step();
        chk("sub_op", bus.out_alu_op, 1);
        chk("sub_rd_we", bus.out_rd_we, 1);
        chk("sub_pc", bus.out_pc, 32'h104);

        offer(32'h40335293, 32'h108);
        step();
        chk("srai_op", bus.out_alu_op, 7);
        chk("srai_b_sel", bus.out_b_sel, 1);
        chk("srai_imm", bus.out_imm, 32'h00000003);
        chk("srai_rs1", bus.out_rs1, 6);
        chk("srai_rd", bus.out_rd, 5);

        offer(32'h123450B7, 32'h10C);
        step();
        chk("lui_op", bus.out_alu_op, 0);
        chk("lui_a_sel", bus.out_a_sel, 2);
        chk("lui_imm", bus.out_imm, 32'h12345000);
        chk("lui_rd_we", bus.out_rd_we, 1);

        offer(32'hFE20CEE3, 32'h110);
        step();
        chk("blt_op", bus.out_alu_op, 3);
        chk("blt_imm", bus.out_imm, 32'hFFFFFFFC);
        chk("blt_b_sel", bus.out_b_sel, 0);
        chk("blt_rd_we", bus.out_rd_we, 0);

        offer(32'h00000000, 32'h114);
        step();
        chk("zero_illegal", bus.out_illegal, 1);
        chk("zero_rd_we", bus.out_rd_we, 0);
        chk("zero_op", bus.out_alu_op, 0);

        offer(32'h402091B3, 32'h118);
        step();
        chk("f7_bad_illegal", bus.out_illegal, 1);
        chk("f7_bad_op", bus.out_alu_op, 0);
        chk("f7_bad_rd_we", bus.out_rd_we, 0);

        offer(32'h00000013, 32'h11C);
        step();
        chk("nop_illegal", bus.out_illegal, 0);
        chk("nop_rd_we_x0", bus.out_rd_we, 0);

        offer(32'h0020A423, 32'h120);
        step();
        chk("sw_imm", bus.out_imm, 32'h00000008);
        chk("sw_b_sel", bus.out_b_sel, 1);
        chk("sw_rd_we", bus.out_rd_we, 0);

        offer(32'h008000EF, 32'h124);
        step();
        chk("jal_a_sel", bus.out_a_sel, 1);
        chk("jal_imm", bus.out_imm, 32'h00000008);
        chk("jal_rd_we", bus.out_rd_we, 1);

        bus.in_valid = 1'b0;
        step();
        chk("idle_out_valid", bus.out_valid, 0);

        // backpressure: A, B, C offered with out_ready low
        bus.out_ready = 1'b0;
        offer(32'h002081B3, 32'hA0);
        step();
        chk("bp_a_out", bus.out_pc, 32'hA0);
        chk("bp_a_in_ready", bus.in_ready, 1);
        offer(32'h002081B3, 32'hB0);
        step();
        chk("bp_b_in_ready", bus.in_ready, 0);
        chk("bp_hold_a", bus.out_pc, 32'hA0);
        offer(32'h002081B3, 32'hC0);
        step();
        chk("bp_c_in_ready", bus.in_ready, 0);
        chk("bp_hold_a2", bus.out_pc, 32'hA0);
        chk("bp_hold_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        step();
        chk("bp_b_out", bus.out_pc, 32'hB0);
        chk("bp_in_ready_back", bus.in_ready, 1);
        step();
        chk("bp_c_out", bus.out_pc, 32'hC0);
        chk("bp_c_valid", bus.out_valid, 1);
        bus.in_valid = 1'b0;
        step();
        chk("bp_drained", bus.out_valid, 0);

        // flush with both entries full and a beat offered
        bus.out_ready = 1'b0;
        offer(32'h002081B3, 32'hD0);
        step();
        offer(32'h002081B3, 32'hE0);
        step();
        chk("fl_full", bus.in_ready, 0);
        flush = 1'b1;
        offer(32'h002081B3, 32'hF0);
        step();
        chk("fl_out_valid", bus.out_valid, 0);
        chk("fl_in_ready", bus.in_ready, 1);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("fl_nothing_after", bus.out_valid, 0);

        // flush with empty buffer and in_ready high still drops the offered beat
        flush = 1'b1;
        offer(32'h002081B3, 32'h1F0);
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_empty_drop", bus.out_valid, 0);
        step();
        chk("fl_empty_drop2", bus.out_valid, 0);

        // reset mid-stream with both entries full
        bus.out_ready = 1'b0;
        offer(32'h002081B3, 32'h200);
        step();
        offer(32'h002081B3, 32'h210);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_out_valid", bus.out_valid, 0);
        chk("mrst_in_ready", bus.in_ready, 1);
        chk("mrst_pc", bus.out_pc, 0);
        bus.out_ready = 1'b1;
        offer(32'h402081B3, 32'h300);
        step();
        chk("mrst_resume_valid", bus.out_valid, 1);
        chk("mrst_resume_pc", bus.out_pc, 32'h300);
        chk("mrst_resume_op", bus.out_alu_op, 1);
        bus.in_valid = 1'b0;
        step();
        chk("mrst_end_valid", bus.out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
